// File: rtl/imem_fetch_arbiter.sv
// Instruction-memory arbiter: shares one word-addressed, waitrequest-style
// memory port between the pipeline fetch stage and the loader/debug port.
// It allows one outstanding transaction. A fetch can be cancelled by a
// branch flush. A watchdog abandons a transaction when the memory stalls for
// too long: a fetch then receives a NOP, and a loader access receives zero.
module imem_fetch_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int TIMEOUT  = 64,
  parameter int FIX_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  input  logic              f_flush,
  output logic              f_valid,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_ack,
  output logic [31:0]       l_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_waitrequest,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_L = 2'd2
  } state_t;

  // The watchdog only ever holds values from 0 to TIMEOUT-1.
  localparam int          WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  state_t          state;
  logic            last_grant_l;  // 1: the loader won the most recent grant
  logic            cancel;
  logic [WD_W-1:0] watchdog;

  logic            f_live;
  logic            grant_f;
  logic            grant_l;
  logic            done;
  logic            expired;
  logic            drop_fetch;
  logic            unused_addr_bits;

  // Byte addresses index words. The upper bits alias, so the address space wraps.
  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                              l_addr[31:ADDR_W+2], l_addr[1:0]};

  // A redirect in IDLE hides the stale fetch request for that cycle.
  assign f_live     = f_req & ~f_flush;
  assign done       = (m_read | m_write) & ~m_waitrequest;
  assign expired    = (m_read | m_write) & m_waitrequest &
                      (watchdog == WD_W'(TIMEOUT - 1));
  // A flush in the completing cycle also kills the result.
  assign drop_fetch = cancel | f_flush;

  // Arbitration between fetch and loader: fixed loader priority, or round-robin on last_grant.
  // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
  always_comb begin
    grant_f = 1'b0;
    grant_l = 1'b0;
    if (f_live && l_req) begin
      if (FIX_PRIO != 0)     grant_l = 1'b1;
      else if (last_grant_l) grant_f = 1'b1;
      else                   grant_l = 1'b1;
    end else if (f_live) begin
      grant_f = 1'b1;
    end else if (l_req) begin
      grant_l = 1'b1;
    end
  end

  // Transaction sequencer: grant, hold the strobe through stalls, then complete or abandon.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant_l <= 1'b1;
      cancel       <= 1'b0;
      watchdog     <= '0;
      timeout_err  <= 1'b0;
      f_valid      <= 1'b0;
      f_rdata      <= '0;
      l_ack        <= 1'b0;
      l_rdata      <= '0;
      m_addr       <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_wdata      <= '0;
    end else begin
      f_valid <= 1'b0;
      l_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_f) begin
            state        <= BUSY_F;
            m_addr       <= f_addr[ADDR_W+1:2];
            m_read       <= 1'b1;
            last_grant_l <= 1'b0;
            watchdog     <= '0;
            cancel       <= 1'b0;
          end else if (grant_l) begin
            state        <= BUSY_L;
            m_addr       <= l_addr[ADDR_W+1:2];
            m_read       <= ~l_we;
            m_write      <= l_we;
            m_wdata      <= l_wdata;
            last_grant_l <= 1'b1;
            watchdog     <= '0;
            cancel       <= 1'b0;
          end
        end

        BUSY_F: begin
          if (done) begin
            state  <= IDLE;
            m_read <= 1'b0;
            if (!drop_fetch) begin
              f_valid <= 1'b1;
              f_rdata <= m_rdata;
            end
          end else if (expired) begin
            state       <= IDLE;
            m_read      <= 1'b0;
            timeout_err <= 1'b1;
            if (!drop_fetch) begin
              f_valid <= 1'b1;
              f_rdata <= NOP;
            end
          end else begin
            watchdog <= watchdog + WD_W'(1);
            if (f_flush) cancel <= 1'b1;
          end
        end

        BUSY_L: begin
          if (done) begin
            state   <= IDLE;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            l_ack   <= 1'b1;
            if (!m_write) l_rdata <= m_rdata;
          end else if (expired) begin
            state       <= IDLE;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            timeout_err <= 1'b1;
            l_ack       <= 1'b1;
            l_rdata     <= '0;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter. It drives inputs and samples outputs
// on the falling clock edge. Expected values are constants worked out by hand.
module tb_imem_fetch_arbiter;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req, f_flush, l_req, l_we;
  logic [31:0]       f_addr, l_addr, l_wdata;
  logic              f_valid, l_ack, m_read, m_write, timeout_err;
  logic [31:0]       f_rdata, l_rdata, m_wdata, m_rdata;
  logic [ADDR_W-1:0] m_addr;
  logic              m_waitrequest;

  int n_pass  = 0;
  int n_total = 0;

  // Write monitor for the memory side.
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  int                wr_cnt = 0;

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(64), .FIX_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_valid(f_valid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_waitrequest(m_waitrequest),
    .timeout_err(timeout_err)
  );

  // Read-only memory contents as a fixed function of the word address.
  function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
    case (a)
      10'd2:   return 32'h0050_0293;
      10'd3:   return 32'h00A0_0313;
      10'd5:   return 32'h1234_5678;
      default: return 32'hC0DE_0000 | 32'(a);
    endcase
  endfunction

  assign m_rdata = rom(m_addr);

  always @(posedge clk) begin
    if (m_write && !m_waitrequest) begin
      wr_addr <= m_addr;
      wr_data <= m_wdata;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    f_req = 1'b0; f_flush = 1'b0; f_addr = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    m_waitrequest = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_strobes", {30'd0, m_read, m_write}, 32'd0);
    check("rst_pulses", {29'd0, f_valid, l_ack, timeout_err}, 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_f_rdata", f_rdata, 32'd0);
    check("rst_l_rdata", l_rdata, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    rst = 1'b1;

    // Fetch only, zero wait: strobe at N+1, valid at N+2
    f_req = 1'b1; f_addr = 32'h8;
    tick();
    f_req = 1'b0;
    check("f1_m_read", {31'd0, m_read}, 32'd1);
    check("f1_m_addr", 32'(m_addr), 32'd2);
    check("f1_no_valid_yet", {31'd0, f_valid}, 32'd0);
    tick();
    check("f1_valid", {31'd0, f_valid}, 32'd1);
    check("f1_rdata", f_rdata, 32'h0050_0293);
    check("f1_strobe_drop", {31'd0, m_read}, 32'd0);
    tick();
    check("f1_valid_pulse", {31'd0, f_valid}, 32'd0);

    // Both requesting, round-robin: last grant was fetch, so L,F,L
    f_req = 1'b1; f_addr = 32'h8;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'hC;
    tick();
    check("rr1_l_addr", 32'(m_addr), 32'd3);
    check("rr1_l_read", {30'd0, m_read, m_write}, 32'd2);
    tick();
    check("rr1_l_ack", {31'd0, l_ack}, 32'd1);
    check("rr1_l_rdata", l_rdata, 32'h00A0_0313);
    tick();
    check("rr2_f_addr", 32'(m_addr), 32'd2);
    check("rr2_f_read", {31'd0, m_read}, 32'd1);
    tick();
    check("rr2_f_valid", {30'd0, f_valid, l_ack}, 32'd2);
    tick();
    check("rr3_l_addr", 32'(m_addr), 32'd3);
    tick();
    check("rr3_l_ack", {30'd0, f_valid, l_ack}, 32'd1);
    f_req = 1'b0; l_req = 1'b0;
    tick();
    check("rr_idle", {30'd0, m_read, m_write}, 32'd0);

    // Loader write with three wait cycles
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
    tick();
    l_req = 1'b0; l_we = 1'b0; l_wdata = 32'h0;
    m_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_hold%0d", i), {m_write, m_read, 20'd0, m_addr}, {1'b1, 1'b0, 20'd0, 10'd4});
      check($sformatf("wr_wdata%0d", i), m_wdata, 32'hDEAD_BEEF);
      check($sformatf("wr_no_ack%0d", i), {31'd0, l_ack}, 32'd0);
      tick();
    end
    m_waitrequest = 1'b0;
    check("wr_hold3", {m_write, 21'd0, m_addr}, {1'b1, 21'd0, 10'd4});
    tick();
    check("wr_ack", {30'd0, l_ack, m_write}, 32'd2);
    check("wr_mem_cnt", 32'(wr_cnt), 32'd1);
    check("wr_mem_addr", 32'(wr_addr), 32'd4);
    check("wr_mem_data", wr_data, 32'hDEAD_BEEF);
    check("wr_l_rdata_kept", l_rdata, 32'h00A0_0313);
    tick();
    check("wr_ack_once", {31'd0, l_ack}, 32'd0);

    // Fetch flushed one cycle after grant, two wait cycles
    f_req = 1'b1; f_addr = 32'h14; m_waitrequest = 1'b1;
    tick();
    f_req = 1'b0; f_flush = 1'b1;
    check("fl_m_addr", 32'(m_addr), 32'd5);
    tick();
    f_flush = 1'b0;
    tick();
    m_waitrequest = 1'b0;
    check("fl_read_held", {31'd0, m_read}, 32'd1);
    tick();
    check("fl_no_valid", {30'd0, f_valid, m_read}, 32'd0);
    check("fl_rdata_kept", f_rdata, 32'h0050_0293);
    tick();
    check("fl_still_no_valid", {31'd0, f_valid}, 32'd0);

    // Stuck memory: watchdog abandons the fetch after 64 wait cycles
    f_req = 1'b1; f_addr = 32'h8; m_waitrequest = 1'b1;
    tick();
    f_req = 1'b0;
    repeat (63) tick();
    check("to_read_at_64", {30'd0, m_read, timeout_err}, 32'd2);
    tick();
    check("to_dropped", {29'd0, m_read, f_valid, timeout_err}, 32'd3);
    check("to_nop", f_rdata, 32'h0000_0013);
    m_waitrequest = 1'b0;
    repeat (3) tick();
    check("to_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of a stalled loader write
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h55; m_waitrequest = 1'b1;
    tick();
    check("rm_write_on", {31'd0, m_write}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rm_async_drop", {29'd0, m_write, m_read, timeout_err}, 32'd0);
    check("rm_f_rdata_clr", f_rdata, 32'd0);
    @(negedge clk);
    check("rm_no_ack", {31'd0, l_ack}, 32'd0);
    rst = 1'b1; m_waitrequest = 1'b0;
    // After reset last_grant is the loader, so fetch wins. The address also wraps to word 2.
    f_req = 1'b1; f_addr = 32'h0000_1008;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'hC;
    tick();
    f_req = 1'b0; l_req = 1'b0;
    check("rm_fetch_first", {30'd0, m_read, m_write}, 32'd2);
    check("rm_wrap_addr", 32'(m_addr), 32'd2);
    tick();
    check("rm_f_valid", {30'd0, f_valid, l_ack}, 32'd2);
    check("rm_f_rdata", f_rdata, 32'h0050_0293);
    check("rm_no_write", 32'(wr_cnt), 32'd1);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
